// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter step sequencer:
// opcodes, sequencer state encoding and default datapath width.
package pc_pkg;

   localparam int PC_W_DEF = 2;

   localparam logic [1:0] OP_INC  = 2'b00;
   localparam logic [1:0] OP_JNO  = 2'b01;
   localparam logic [1:0] OP_CLRS = 2'b10;
   localparam logic [1:0] OP_HALT = 2'b11;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      ISSUE    = 3'd1,
      WAIT_ACK = 3'd2,
      COMMIT   = 3'd3,
      EXEC     = 3'd4,
      HALTED   = 3'd5
   } pc_state_e;

endpackage

// File: rtl/ack_sync.sv
// Brings the incrementer's asynchronous ack pulse into the clk domain
// and reduces it to a single-cycle strobe on its rising edge.
module ack_sync (
   input  logic clk,
   input  logic reset,
   input  logic ack,
   output logic ack_rise
);

   logic sync_1;
   logic sync_2;
   logic sync_3;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_1 <= 1'b0;
         sync_2 <= 1'b0;
         sync_3 <= 1'b0;
      end else begin
         sync_1 <= ack;
         sync_2 <= sync_1;
         sync_3 <= sync_2;
      end
   end

   assign ack_rise = sync_2 & ~sync_3;

endmodule

// File: rtl/pc_step_ctrl.sv
// Step sequencer: runs the pulse/ack handshake with the incrementer for INC,
// executes JNO/CLRS locally, and parks in HALTED on HALT until reset.
module pc_step_ctrl
   import pc_pkg::*;
#(
   parameter int PC_W      = PC_W_DEF,
   parameter int PULSE_LEN = 2,
   parameter int ACK_TMO   = 8
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            step_req,
   input  logic [1:0]      instr,
   input  logic [PC_W-1:0] jump_target,
   input  logic [PC_W-1:0] adder_sum,
   input  logic            adder_carry,
   input  logic            inc_ack,
   output logic [1:0]      instr_checked,
   output logic            step_pulse,
   output logic [PC_W-1:0] pc_out,
   output logic            status,
   output logic            busy,
   output logic            step_done,
   output logic            halted,
   output logic            timeout_err,
   output pc_state_e       state_dbg
);

   // Handshake: a step is accepted only when step_req is high while the
   // sequencer is IDLE; step_done is a one-cycle strobe marking the commit.
   localparam int CNT_MAX = (PULSE_LEN > ACK_TMO) ? PULSE_LEN : ACK_TMO;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   pc_state_e       state;
   pc_state_e       next_state;
   logic [CNT_W-1:0] cnt;
   logic [1:0]      op_q;
   logic [PC_W-1:0] target_q;
   logic            ack_rise;
   logic            timeout_set;
   logic            accept;

   ack_sync u_ack_sync (
      .clk      (clk),
      .reset    (reset),
      .ack      (inc_ack),
      .ack_rise (ack_rise)
   );

   assign accept = (state == IDLE) && step_req;

   always_comb begin
      next_state  = state;
      timeout_set = 1'b0;
      case (state)
         IDLE: begin
            if (step_req) begin
               case (instr)
                  OP_INC:  next_state = ISSUE;
                  OP_HALT: next_state = HALTED;
                  default: next_state = EXEC;
               endcase
            end
         end
         ISSUE: begin
            if (cnt == CNT_W'(PULSE_LEN - 1)) next_state = WAIT_ACK;
         end
         WAIT_ACK: begin
            if (ack_rise) begin
               next_state = COMMIT;
            end else if (cnt == CNT_W'(ACK_TMO - 1)) begin
               next_state  = IDLE;
               timeout_set = 1'b1;
            end
         end
         COMMIT:  next_state = IDLE;
         EXEC:    next_state = IDLE;
         HALTED:  next_state = HALTED;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         cnt           <= '0;
         op_q          <= OP_INC;
         target_q      <= '0;
         instr_checked <= OP_HALT;
         pc_out        <= '0;
         status        <= 1'b0;
         timeout_err   <= 1'b0;
      end else begin
         state <= next_state;

         // One counter times both the pulse width and the ack wait.
         if ((next_state != state) || ((state != ISSUE) && (state != WAIT_ACK)))
            cnt <= '0;
         else
            cnt <= cnt + 1'b1;

         if (accept) begin
            op_q     <= instr;
            target_q <= jump_target;
         end

         // 2'b11 keeps the incrementer idle whenever no step is in flight.
         if ((next_state == IDLE) && (state != IDLE))
            instr_checked <= OP_HALT;
         else if (accept)
            instr_checked <= instr;

         if (timeout_set) timeout_err <= 1'b1;

         if (state == COMMIT) begin
            pc_out <= adder_sum;
            status <= status | adder_carry;
         end

         if (state == EXEC) begin
            if ((op_q == OP_JNO) && !status) pc_out <= target_q;
            if (op_q == OP_CLRS) status <= 1'b0;
         end
      end
   end

   assign step_pulse = (state == ISSUE);
   assign step_done  = (state == COMMIT) || (state == EXEC);
   assign halted     = (state == HALTED);
   assign busy       = (state != IDLE) && (state != HALTED);
   assign state_dbg  = state;

endmodule
